mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage controller of the five-stage pipeline: the consumer side of the EX/MEM pipeline register. It accepts the EX/MEM register outputs, performs word loads/stores over a variable-latency `req/ready` data-memory port, and drives the MEM/WB register fields. While an access is outstanding it back-pressures the upstream stages with `MEM_stall`.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `dmem_ready` before the access is aborted. Legal range is 1..255.
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-low: asserted when 0; it acts immediately, without waiting for a clock edge.
- `EX_MEM_ALU_result`  in  32  — ALU result; used as the memory address for loads and stores.
- `EX_MEM_rs2_data`  in  32  — store data.
- `EX_MEM_rd`  in  5  — destination register.
- `EX_MEM_regwrite`, `EX_MEM_memtoreg`, `EX_MEM_memread`, `EX_MEM_memwrite`  in  1 each  — control bits.
- `dmem_ready`  in  1  — memory completes the request this cycle.
- `dmem_rdata`  in  32  — load data; valid when `dmem_ready`=1.
- `dmem_req`  out  1  — request valid; registered.
- `dmem_we`  out  1  — 1 = store; registered.
- `dmem_addr`  out  32  — word address; registered, with bits [1:0] = 0.
- `dmem_wdata`  out  32  — store data; registered.
- `MEM_stall`  out  1  — combinational; holds the IF, ID, EX and EX/MEM registers.
- `MEM_WB_ALU_result`, `MEM_WB_read_data`  out  32 each  — registered.
- `MEM_WB_rd`  out  5; `MEM_WB_regwrite`, `MEM_WB_memtoreg`  out  1 each  — registered.
- `MEM_misaligned`  out  1  — registered one-cycle pulse: access suppressed because address bits [1:0] ≠ 0.
- `MEM_bus_error`  out  1  — registered one-cycle pulse: access aborted by timeout.

## Operation
- **States.** Two states: IDLE and BUSY. The op is a memory op when `memop` = `EX_MEM_memread | EX_MEM_memwrite`.
- **IDLE, non-memory op.**
  - MEM/WB loads the EX/MEM fields at the next edge; `MEM_WB_read_data` loads 0.
  - `MEM_stall`=0.
- **IDLE, memory op, address bits [1:0] ≠ 0.**
  - No access is made; `MEM_stall`=0.
  - Next edge: `MEM_misaligned`=1 and the op retires with `MEM_WB_regwrite`=0.
- **IDLE, memory op, aligned address.**
  - `MEM_stall`=1 for this cycle.
  - Next edge: latch address, write data, `rd`, `regwrite` and `memtoreg`; set `dmem_req`=1, `dmem_we`=`EX_MEM_memwrite`, clear the counter; go to BUSY; MEM/WB receives a bubble (`regwrite`=0, `memtoreg`=0, `rd`=0).
  - If both `memread` and `memwrite` are 1, the store wins.
- **BUSY, `dmem_ready`=0.**
  - `MEM_stall`=1; MEM/WB receives a bubble; the counter increments.
  - When the counter equals `TIMEOUT`-1 (the `TIMEOUT`-th BUSY cycle without ready): `MEM_stall`=0 for this cycle. Next edge: `dmem_req`=0, `MEM_bus_error`=1, the latched op retires with `MEM_WB_regwrite`=0, go to IDLE.
- **BUSY, `dmem_ready`=1.**
  - `MEM_stall`=0 for this cycle.
  - Next edge: `dmem_req`=0; MEM/WB loads the latched fields, with `MEM_WB_read_data`=`dmem_rdata` for a load and 0 for a store; go to IDLE.
- **`rd`=0.** `MEM_WB_regwrite` is forced to 0 for every retiring op with `rd`=0.
- **Request hold.** `dmem_addr`, `dmem_wdata` and `dmem_we` stay constant while `dmem_req`=1.
- **Reset.**
  - State goes to IDLE; every output and register goes to 0, including `dmem_req`.
  - Reset during BUSY abandons the access: no `MEM_bus_error` pulse and no retire.

## Timing
- **Non-memory op latency.** 1 cycle from EX/MEM to MEM/WB.
- **Memory op latency.** Takes N+1 cycles, where N ≥ 1 is the number of BUSY cycles up to and including the ready cycle.
  - The minimum is 2 cycles, when `dmem_ready` arrives in the first BUSY cycle.
  - `MEM_stall` is high for N cycles: the accept cycle plus the N-1 BUSY cycles without ready.
- **Ready-to-retire.** Upstream advances on the same edge that retires the memory op, so back-to-back memory ops carry no bubble beyond the BUSY cycles.
- **Ignored `dmem_ready`.** `dmem_ready` in IDLE is ignored.
- **Late ready after abort.** `dmem_ready` arriving on the edge after an abort is ignored.
- **Pulse width.** `MEM_misaligned` and `MEM_bus_error` are each exactly 1 cycle wide.

## Test plan
- **ALU op pass-through.** ALU op (`regwrite`=1, `rd`=5, result=0x1234) in IDLE → next cycle `MEM_WB_rd`=5, `regwrite`=1, `ALU_result`=0x1234; `MEM_stall` never high.
- **Load, 3-cycle memory.** Load at 0x100, memory ready in the 3rd BUSY cycle with rdata=0xDEADBEEF.
  - `dmem_req` high for 3 cycles with `addr`=0x100 and `we`=0.
  - `MEM_stall` high for 3 cycles.
  - `MEM_WB_read_data`=0xDEADBEEF with `memtoreg`=1 on the following cycle.
- **Store with immediate ready.** Store of 0xCAFEF00D to 0x40, ready in the 1st BUSY cycle.
  - `dmem_we`=1, `dmem_wdata`=0xCAFEF00D.
  - Total 2-cycle occupancy.
  - Next op (ALU, `rd`=7) retires in the cycle immediately after.
- **Misaligned load.** Load at 0x102 → no `dmem_req`; one-cycle `MEM_misaligned`; `MEM_WB_regwrite`=0.
- **Timeout.** `TIMEOUT`=4, `dmem_ready` held 0 → `dmem_req` high for 4 cycles, then `MEM_bus_error` pulses; `MEM_WB_regwrite`=0; state IDLE.
- **Reset in BUSY.** Assert reset (drive to 0) mid-BUSY → `dmem_req` drops to 0 immediately, before any edge, and all outputs are 0. After release, an ALU op passes through normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller driving a req/ready data memory and the MEM/WB register
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] EX_MEM_ALU_result,
   input  logic [31:0] EX_MEM_rs2_data,
   input  logic [4:0]  EX_MEM_rd,
   input  logic        EX_MEM_regwrite,
   input  logic        EX_MEM_memtoreg,
   input  logic        EX_MEM_memread,
   input  logic        EX_MEM_memwrite,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        MEM_stall,
   output logic [31:0] MEM_WB_ALU_result,
   output logic [31:0] MEM_WB_read_data,
   output logic [4:0]  MEM_WB_rd,
   output logic        MEM_WB_regwrite,
   output logic        MEM_WB_memtoreg,
   output logic        MEM_misaligned,
   output logic        MEM_bus_error
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
   logic        mis_q, mis_d, berr_q, berr_d;
   logic        memop, aligned, expired;
   assign memop   = EX_MEM_memread | EX_MEM_memwrite;
   assign aligned = EX_MEM_ALU_result[1:0] == 2'b00;
   assign expired = cnt_q == LAST;
   // Stall upstream while an aligned access is being accepted or is still waiting; never while in reset
   assign MEM_stall = reset & (state_q == IDLE ? memop & aligned : ~dmem_ready & ~expired);
   // Next-state: accept, wait, complete or abort an access, and compute the MEM/WB payload
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_alu_d   = '0;
      wb_rdata_d = '0;
      wb_rd_d    = '0;
      wb_rw_d    = 1'b0;
      wb_m2r_d   = 1'b0;
      mis_d      = 1'b0;
      berr_d     = 1'b0;
      if (state_q == IDLE) begin
         if (memop && aligned) begin
            rd_d       = EX_MEM_rd;
            regwrite_d = EX_MEM_regwrite;
            memtoreg_d = EX_MEM_memtoreg;
            req_d      = 1'b1;
            we_d       = EX_MEM_memwrite;
            addr_d     = {EX_MEM_ALU_result[31:2], 2'b00};
            wdata_d    = EX_MEM_rs2_data;
            cnt_d      = '0;
            state_d    = BUSY;
         end else begin
            wb_alu_d = EX_MEM_ALU_result;
            wb_rd_d  = EX_MEM_rd;
            wb_rw_d  = EX_MEM_regwrite & ~memop & (EX_MEM_rd != 5'd0);
            wb_m2r_d = EX_MEM_memtoreg;
            mis_d    = memop;
         end
      end else if (dmem_ready) begin
         req_d      = 1'b0;
         wb_alu_d   = addr_q;
         wb_rdata_d = we_q ? 32'd0 : dmem_rdata;
         wb_rd_d    = rd_q;
         wb_rw_d    = regwrite_q & (rd_q != 5'd0);
         wb_m2r_d   = memtoreg_q;
         state_d    = IDLE;
      end else if (expired) begin
         req_d    = 1'b0;
         berr_d   = 1'b1;
         wb_alu_d = addr_q;
         wb_rd_d  = rd_q;
         wb_m2r_d = memtoreg_q;
         state_d  = IDLE;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end
   // State and registered outputs; reset abandons any outstanding access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_alu_q   <= '0;
         wb_rdata_q <= '0;
         wb_rd_q    <= '0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
         mis_q      <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_alu_q   <= wb_alu_d;
         wb_rdata_q <= wb_rdata_d;
         wb_rd_q    <= wb_rd_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
         mis_q      <= mis_d;
         berr_q     <= berr_d;
      end
   end
   assign dmem_req          = req_q;
   assign dmem_we           = we_q;
   assign dmem_addr         = addr_q;
   assign dmem_wdata        = wdata_q;
   assign MEM_WB_ALU_result = wb_alu_q;
   assign MEM_WB_read_data  = wb_rdata_q;
   assign MEM_WB_rd         = wb_rd_q;
   assign MEM_WB_regwrite   = wb_rw_q;
   assign MEM_WB_memtoreg   = wb_m2r_q;
   assign MEM_misaligned    = mis_q;
   assign MEM_bus_error     = berr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table vectors plus multi-cycle sequences, MEM/WB checked through a scoreboard
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] EX_MEM_ALU_result, EX_MEM_rs2_data, dmem_rdata;
   logic [4:0]  EX_MEM_rd;
   logic        EX_MEM_regwrite, EX_MEM_memtoreg, EX_MEM_memread, EX_MEM_memwrite, dmem_ready;
   logic        dmem_req, dmem_we, MEM_stall, MEM_WB_regwrite, MEM_WB_memtoreg, MEM_misaligned, MEM_bus_error;
   logic [31:0] dmem_addr, dmem_wdata, MEM_WB_ALU_result, MEM_WB_read_data;
   logic [4:0]  MEM_WB_rd;
   int pass_cnt = 0;
   int total_cnt = 0;
   typedef struct {
      logic [4:0]  rd;
      logic        rw, m2r;
      logic [31:0] alu, rdata;
      logic        mis, berr;
   } wb_t;
   wb_t sb[$];
   typedef struct {
      logic [31:0] alu, rs2;
      logic [4:0]  rd;
      logic        rw, m2r, mr, mw;
      logic        e_rw, e_mis;
   } vec_t;
   vec_t vecs[6];

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rs2_data(EX_MEM_rs2_data), .EX_MEM_rd(EX_MEM_rd),
      .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memtoreg(EX_MEM_memtoreg),
      .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .MEM_stall(MEM_stall), .MEM_WB_ALU_result(MEM_WB_ALU_result), .MEM_WB_read_data(MEM_WB_read_data),
      .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_memtoreg(MEM_WB_memtoreg),
      .MEM_misaligned(MEM_misaligned), .MEM_bus_error(MEM_bus_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s act=%h exp=%h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic mr, input logic mw);
      EX_MEM_ALU_result = alu;
      EX_MEM_rs2_data   = rs2;
      EX_MEM_rd         = rd;
      EX_MEM_regwrite   = rw;
      EX_MEM_memtoreg   = m2r;
      EX_MEM_memread    = mr;
      EX_MEM_memwrite   = mw;
   endtask

   task automatic push(input logic [4:0] rd, input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic mis, input logic berr);
      wb_t w;
      w.rd = rd; w.rw = rw; w.m2r = m2r; w.alu = alu; w.rdata = rdata; w.mis = mis; w.berr = berr;
      sb.push_back(w);
   endtask

   task automatic check_wb();
      wb_t w;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      w = sb.pop_front();
      chk("wb_rd", 32'(MEM_WB_rd), 32'(w.rd));
      chk("wb_regwrite", 32'(MEM_WB_regwrite), 32'(w.rw));
      chk("wb_memtoreg", 32'(MEM_WB_memtoreg), 32'(w.m2r));
      chk("wb_alu", MEM_WB_ALU_result, w.alu);
      chk("wb_rdata", MEM_WB_read_data, w.rdata);
      chk("misaligned", 32'(MEM_misaligned), 32'(w.mis));
      chk("bus_error", 32'(MEM_bus_error), 32'(w.berr));
   endtask

   // one-cycle op: entered and left at a negedge
   task automatic single(input vec_t v);
      drive(v.alu, v.rs2, v.rd, v.rw, v.m2r, v.mr, v.mw);
      push(v.rd, v.e_rw, v.m2r, v.alu, 32'd0, v.e_mis, 1'b0);
      #1;
      chk("single_stall", 32'(MEM_stall), 32'd0);
      chk("single_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      check_wb();
      @(negedge clk);
   endtask

   // memory op spanning n BUSY cycles; rdy=0 means no ready ever (timeout expected at n)
   task automatic run_mem(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic mr, input logic mw,
                          input int n, input logic rdy, input logic [31:0] rdata,
                          input logic e_rw, input logic [31:0] e_rdata);
      int stalls = 0;
      int reqs = 0;
      drive(alu, rs2, rd, rw, m2r, mr, mw);
      push(rd, e_rw, m2r, alu, e_rdata, 1'b0, !rdy);
      for (int c = 0; c <= n; c++) begin
         dmem_ready = rdy && c == n;
         dmem_rdata = (rdy && c == n) ? rdata : 32'h0BAD0BAD;
         #1;
         if (MEM_stall) stalls++;
         if (dmem_req) reqs++;
         if (c > 0) begin
            chk("req_addr", dmem_addr, alu);
            chk("req_we", 32'(dmem_we), 32'(mw));
            chk("req_wdata", dmem_wdata, rs2);
         end
         @(posedge clk); #1;
         if (c < n) chk("bubble_rw", 32'(MEM_WB_regwrite), 32'd0);
         else begin
            check_wb();
            chk("req_drop", 32'(dmem_req), 32'd0);
         end
         @(negedge clk);
      end
      dmem_ready = 1'b0;
      chk("stall_cycles", 32'(stalls), 32'(n));
      chk("req_cycles", 32'(reqs), 32'(n));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
      chk({tag, "_we"}, 32'(dmem_we), 32'd0);
      chk({tag, "_addr"}, dmem_addr, 32'd0);
      chk({tag, "_wdata"}, dmem_wdata, 32'd0);
      chk({tag, "_stall"}, 32'(MEM_stall), 32'd0);
      chk({tag, "_wb_alu"}, MEM_WB_ALU_result, 32'd0);
      chk({tag, "_wb_rdata"}, MEM_WB_read_data, 32'd0);
      chk({tag, "_wb_ctl"}, {25'd0, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_memtoreg}, 32'd0);
      chk({tag, "_pulses"}, {30'd0, MEM_misaligned, MEM_bus_error}, 32'd0);
   endtask

   initial begin
      vec_t nop, alu7;
      vecs[0] = '{alu: 32'h1234,     rs2: 32'h0, rd: 5'd5,  rw: 1, m2r: 0, mr: 0, mw: 0, e_rw: 1, e_mis: 0};
      vecs[1] = '{alu: 32'h55,       rs2: 32'h9, rd: 5'd0,  rw: 1, m2r: 0, mr: 0, mw: 0, e_rw: 0, e_mis: 0};
      vecs[2] = '{alu: 32'h102,      rs2: 32'h0, rd: 5'd3,  rw: 1, m2r: 1, mr: 1, mw: 0, e_rw: 0, e_mis: 1};
      vecs[3] = '{alu: 32'h41,       rs2: 32'h7, rd: 5'd0,  rw: 0, m2r: 0, mr: 0, mw: 1, e_rw: 0, e_mis: 1};
      vecs[4] = '{alu: 32'hFFFFFFFF, rs2: 32'h0, rd: 5'd31, rw: 0, m2r: 0, mr: 0, mw: 0, e_rw: 0, e_mis: 0};
      vecs[5] = '{alu: 32'hA5A5A5A5, rs2: 32'h0, rd: 5'd7,  rw: 1, m2r: 1, mr: 0, mw: 0, e_rw: 1, e_mis: 0};
      nop  = '{alu: 32'h0,  rs2: 32'h0, rd: 5'd0, rw: 0, m2r: 0, mr: 0, mw: 0, e_rw: 0, e_mis: 0};
      alu7 = '{alu: 32'h77, rs2: 32'h0, rd: 5'd7, rw: 1, m2r: 0, mr: 0, mw: 0, e_rw: 1, e_mis: 0};
      reset = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      drive(32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         dmem_ready = 1'(i % 2);
         single(vecs[i]);
      end
      dmem_ready = 1'b0;
      single(nop);
      run_mem(32'h100, 32'h0, 5'd4, 1, 1, 1, 0, 3, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
      run_mem(32'h40, 32'hCAFEF00D, 5'd0, 0, 0, 0, 1, 1, 1'b1, 32'h13572468, 1'b0, 32'h0);
      single(alu7);
      run_mem(32'h80, 32'h11112222, 5'd6, 1, 1, 1, 1, 2, 1'b1, 32'h99998888, 1'b1, 32'h0);
      run_mem(32'h84, 32'h0, 5'd0, 1, 1, 1, 0, 1, 1'b1, 32'h44443333, 1'b0, 32'h44443333);
      run_mem(32'h200, 32'h0, 5'd9, 1, 1, 1, 0, 4, 1'b0, 32'h0, 1'b0, 32'h0);
      dmem_ready = 1'b1;
      single(alu7);
      dmem_ready = 1'b0;
      drive(32'h300, 32'h0, 5'd2, 1, 1, 1, 0);
      @(posedge clk); @(posedge clk); #1;
      chk("pre_reset_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk); #1;
      check_all_zero("held_reset");
      @(negedge clk);
      reset = 1'b1;
      single(vecs[0]);
      single(nop);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
